// File: rtl/fpu_norm_shl_pkg.sv
// Shared definitions for the left-shift normalizer: FSM state encoding
// and default widths used by the top and the per-cycle step datapath.
package fpu_norm_shl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } norm_state_e;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_CNT_W  = 6;
  localparam int DEF_EXP_W  = 12;
  localparam int DEF_STEP   = 16;

endpackage

// File: rtl/fpu_norm_shl_step.sv
// One normalization step: shift by s = min(rem, STEP), adjusting the
// exponent and the remaining shift count by the same amount.
module fpu_norm_shl_step
  import fpu_norm_shl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int STEP   = DEF_STEP
) (
  input  logic [DATA_W-1:0] frac_i,
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [CNT_W-1:0]  rem_i,
  output logic [DATA_W-1:0] frac_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [CNT_W-1:0]  rem_o
);

  // One extra bit so STEP == DATA_W is still representable.
  localparam logic [CNT_W:0] STEP_C = (CNT_W+1)'(STEP);

  logic [CNT_W:0] rem_ext;
  logic [CNT_W:0] s;

  // Clip the remaining shift to the per-cycle maximum and apply it.
  always_comb begin
    rem_ext = {1'b0, rem_i};
    s       = (rem_ext > STEP_C) ? STEP_C : rem_ext;
    frac_o  = frac_i << s;
    exp_o   = exp_i - EXP_W'(s);
    rem_o   = CNT_W'(rem_ext - s);
  end

endmodule

// File: rtl/fpu_norm_shl_seq.sv
// Iterative left-shift normalizer. Accepts a fraction with its lead-0
// count and biased exponent, shifts it left at most STEP bits per cycle,
// and floors the exponent at 1 (flagging a denormal result).
module fpu_norm_shl_seq
  import fpu_norm_shl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int EXP_W  = DEF_EXP_W,
  parameter int STEP   = DEF_STEP
) (
  input  logic              rclk,
  input  logic              arst_l,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_frac,
  input  logic [CNT_W-1:0]  in_lead0,
  input  logic              in_eq_0,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [DATA_W-1:0] out_frac,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_zero,
  output logic              out_denorm
);

  localparam int CMP_W = EXP_W + CNT_W;

  norm_state_e       state_q, state_d;
  logic [DATA_W-1:0] frac_q, frac_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              zero_q, zero_d;
  logic              denorm_q, denorm_d;

  logic [CNT_W-1:0]  shamt;
  logic [CMP_W-1:0]  lead0_w;
  logic [CMP_W-1:0]  exp_m1_w;

  logic [DATA_W-1:0] step_frac;
  logic [EXP_W-1:0]  step_exp;
  logic [CNT_W-1:0]  step_rem;

  fpu_norm_shl_step #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .EXP_W  (EXP_W),
    .STEP   (STEP)
  ) u_step (
    .frac_i (frac_q),
    .exp_i  (exp_q),
    .rem_i  (rem_q),
    .frac_o (step_frac),
    .exp_o  (step_exp),
    .rem_o  (step_rem)
  );

  // Total shift for a new operand: lead-0 count limited so exponent stays >= 1.
  always_comb begin
    lead0_w  = CMP_W'(in_lead0);
    exp_m1_w = CMP_W'(in_exp - EXP_W'(1));
    if (in_eq_0 || (in_exp <= EXP_W'(1))) begin
      shamt = '0;
    end else if (lead0_w > exp_m1_w) begin
      shamt = CNT_W'(exp_m1_w);
    end else begin
      shamt = in_lead0;
    end
  end

  // Next-state and datapath update; everything holds unless a state acts.
  always_comb begin
    state_d  = state_q;
    frac_d   = frac_q;
    exp_d    = exp_q;
    rem_d    = rem_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    case (state_q)
      IDLE: begin
        if (in_vld) begin
          frac_d   = in_frac;
          exp_d    = in_exp;
          rem_d    = shamt;
          zero_d   = in_eq_0;
          denorm_d = !in_eq_0 && (in_lead0 > shamt);
          state_d  = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        frac_d = step_frac;
        exp_d  = step_exp;
        rem_d  = step_rem;
        if (step_rem == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and operand registers; reset discards any operand in flight.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q  <= IDLE;
      frac_q   <= '0;
      exp_q    <= '0;
      rem_q    <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      frac_q   <= frac_d;
      exp_q    <= exp_d;
      rem_q    <= rem_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end

  assign in_rdy     = (state_q == IDLE);
  assign out_vld    = (state_q == DONE);
  assign out_frac   = frac_q;
  assign out_exp    = exp_q;
  assign out_zero   = zero_q;
  assign out_denorm = denorm_q;

endmodule

// File: tb/tb_fpu_norm_shl_seq.sv
// Bench for the left-shift normalizer: a behavioural model predicts each
// result and its output cycle; one checker process compares every cycle.
module tb_fpu_norm_shl_seq;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 6;
  localparam int EXP_W  = 12;
  localparam int STEP   = 16;

  logic              rclk;
  logic              arst_l;
  logic              in_vld;
  logic              in_rdy;
  logic [DATA_W-1:0] in_frac;
  logic [CNT_W-1:0]  in_lead0;
  logic              in_eq_0;
  logic [EXP_W-1:0]  in_exp;
  logic              out_vld;
  logic              out_rdy;
  logic [DATA_W-1:0] out_frac;
  logic [EXP_W-1:0]  out_exp;
  logic              out_zero;
  logic              out_denorm;

  fpu_norm_shl_seq #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .EXP_W  (EXP_W),
    .STEP   (STEP)
  ) dut (
    .rclk       (rclk),
    .arst_l     (arst_l),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_frac    (in_frac),
    .in_lead0   (in_lead0),
    .in_eq_0    (in_eq_0),
    .in_exp     (in_exp),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_frac   (out_frac),
    .out_exp    (out_exp),
    .out_zero   (out_zero),
    .out_denorm (out_denorm)
  );

  typedef struct {
    logic [DATA_W-1:0] frac;
    logic [EXP_W-1:0]  exp;
    bit                zero;
    bit                denorm;
    int                lat;
    int                due;
  } res_t;

  res_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   n_txn  = 0;
  int   ordy_mode = 1;   // 0: hold low, 1: tie high, 2: random

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  always @(posedge rclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Result straight from the normalization rules.
  function automatic res_t model(input logic [DATA_W-1:0] f, input int l0,
                                 input bit z, input int e);
    res_t r;
    int sh;
    if (z || e <= 1) sh = 0;
    else sh = (l0 < e - 1) ? l0 : e - 1;
    r.frac   = f << sh;
    r.exp    = EXP_W'(e - sh);
    r.zero   = z;
    r.denorm = !z && (l0 > sh);
    r.lat    = 1 + (sh + STEP - 1) / STEP;
    r.due    = 0;
    return r;
  endfunction

  // Downstream ready driver.
  initial begin
    out_rdy = 1'b0;
    forever begin
      @(posedge rclk);
      #1;
      case (ordy_mode)
        0:       out_rdy = 1'b0;
        1:       out_rdy = 1'b1;
        default: out_rdy = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Offer one operand, wait (bounded) for acceptance, log its prediction.
  task automatic send(input logic [DATA_W-1:0] f, input int l0, input bit z, input int e);
    res_t r;
    int   w;
    bit   got;
    int   acc;
    w = 0; got = 0; acc = 0;
    in_frac = f; in_lead0 = CNT_W'(l0); in_eq_0 = z; in_exp = EXP_W'(e); in_vld = 1'b1;
    while (!got && w < 300) begin
      @(negedge rclk);
      if (in_rdy) begin
        got = 1;
        acc = cyc;
      end else begin
        w++;
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_rdy never high, got 0 expected 1");
      in_vld = 1'b0;
      return;
    end
    @(posedge rclk);
    r = model(f, l0, z, e);
    r.due = acc + r.lat;
    q.push_back(r);
    #1 in_vld = 1'b0;
  endtask

  task automatic send_rand();
    logic [DATA_W-1:0] f;
    int l0, e;
    bit z;
    l0 = $urandom_range(0, DATA_W - 1);
    f  = {$urandom, $urandom};
    f[DATA_W-1] = 1'b1;
    f  = f >> l0;
    z  = ($urandom_range(0, 9) == 0);
    if (z) f = '0;
    case ($urandom_range(0, 3))
      0:       e = $urandom_range(0, 3);
      1:       e = $urandom_range(0, 70);
      2:       e = $urandom_range(0, 4095);
      default: e = 4095;
    endcase
    send(f, l0, z, e);
  endtask

  // Per-cycle checker: handshake, latency, result fields, hold stability.
  initial begin
    bit                seen;
    bit                held;
    logic [DATA_W-1:0] p_frac;
    logic [EXP_W-1:0]  p_exp;
    logic              p_zero, p_den;
    seen = 0; held = 0; p_frac = '0; p_exp = '0; p_zero = 0; p_den = 0;
    forever begin
      @(negedge rclk);
      if (!arst_l) begin
        held = 0;
        continue;
      end
      chk("in_rdy", in_rdy, (q.size() == 0));
      if (held) begin
        chk("hold_frac", out_frac, p_frac);
        chk("hold_exp", out_exp, p_exp);
        chk("hold_zero", out_zero, p_zero);
        chk("hold_denorm", out_den_w(), p_den);
      end
      held = 0;
      if (q.size() == 0) begin
        chk("out_vld_idle", out_vld, 1'b0);
        seen = 0;
      end else if (!out_vld) begin
        if (seen) chk("out_vld_dropped", out_vld, 1'b1);
        else if (cyc == q[0].due) chk("out_vld_late", out_vld, 1'b1);
      end else begin
        if (!seen) chk("latency", 64'(cyc), 64'(q[0].due));
        seen = 1;
        chk("out_frac", out_frac, q[0].frac);
        chk("out_exp", out_exp, q[0].exp);
        chk("out_zero", out_zero, q[0].zero);
        chk("out_denorm", out_denorm, q[0].denorm);
        if (out_rdy) begin
          $display("txn %0d: frac=%h exp=%h zero=%0b denorm=%0b cycle=%0d",
                   n_txn, out_frac, out_exp, out_zero, out_denorm, cyc);
          n_txn++;
          void'(q.pop_front());
          seen = 0;
        end else begin
          held = 1; p_frac = out_frac; p_exp = out_exp; p_zero = out_zero; p_den = out_denorm;
        end
      end
    end
  end

  function automatic logic out_den_w();
    return out_denorm;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t m;
    int   w;
    arst_l = 1'b0;
    in_vld = 1'b0; in_frac = '0; in_lead0 = '0; in_eq_0 = 1'b0; in_exp = '0;

    // Model pinned against hand-computed values.
    m = model(64'h0000_0000_0000_0001, 63, 0, 12'h400);
    chk("model_t1_frac", m.frac, 64'h8000_0000_0000_0000);
    chk("model_t1_exp", m.exp, 12'h3C1);
    chk("model_t1_lat", 64'(m.lat), 5);
    m = model(64'h0001_0000_0000_0000, 15, 0, 12'h008);
    chk("model_t2_frac", m.frac, 64'h0080_0000_0000_0000);
    chk("model_t2_exp", m.exp, 12'h001);
    chk("model_t2_den", m.denorm, 1'b1);
    chk("model_t2_lat", 64'(m.lat), 2);
    m = model(64'h0, 7, 1, 12'h3FF);
    chk("model_t3_exp", m.exp, 12'h3FF);
    chk("model_t3_lat", 64'(m.lat), 1);
    m = model(64'h0400_0000_0000_0000, 5, 0, 0);
    chk("model_e0_den", m.denorm, 1'b1);

    // Reset values while held in reset.
    #3;
    chk("rst_in_rdy", in_rdy, 1'b1);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_frac", out_frac, 64'h0);
    chk("rst_out_exp", out_exp, 12'h0);
    chk("rst_out_zero", out_zero, 1'b0);
    chk("rst_out_denorm", out_denorm, 1'b0);
    #20 arst_l = 1'b1;
    @(posedge rclk); #1;

    // Directed operands.
    ordy_mode = 1;
    send(64'h0000_0000_0000_0001, 63, 0, 12'h400);
    send(64'h0001_0000_0000_0000, 15, 0, 12'h008);
    send(64'h0, 0, 1, 12'h3FF);
    send(64'h0000_0100_0000_0000, 23, 0, 12'h001);
    send(64'h0000_0100_0000_0000, 23, 0, 12'h000);

    // Pass-through held by back-pressure; a second operand must be ignored.
    ordy_mode = 0;
    send(64'h9234_5678_9ABC_DEF0, 0, 0, 12'h123);
    in_frac = 64'h0000_0000_0000_00FF; in_lead0 = 56; in_eq_0 = 0; in_exp = 12'h200; in_vld = 1'b1;
    repeat (6) @(posedge rclk);
    #1 in_vld = 1'b0;
    ordy_mode = 1;

    // Reset during the second SHIFT cycle.
    send(64'h0000_0000_0000_8000, 48, 0, 12'h400);
    @(posedge rclk);
    #1 arst_l = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_vld", out_vld, 1'b0);
    chk("mid_rst_in_rdy", in_rdy, 1'b1);
    chk("mid_rst_out_frac", out_frac, 64'h0);
    chk("mid_rst_out_exp", out_exp, 12'h0);
    #1 arst_l = 1'b1;
    send(64'h0000_0000_0000_8000, 48, 0, 12'h400);

    // Back-to-back with out_rdy tied high, then random back-pressure.
    for (int i = 0; i < 30; i++) send_rand();
    ordy_mode = 2;
    for (int i = 0; i < 200; i++) send_rand();
    ordy_mode = 1;

    w = 0;
    while (q.size() != 0 && w < 500) begin
      @(negedge rclk);
      w++;
    end
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    repeat (3) @(posedge rclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
